// File: rtl/rom_fetch_sequencer_pkg.sv
// Shared CPU definitions: field widths, opcode map and the fetch-state encoding.
package rom_fetch_sequencer_pkg;

    localparam int ROM_WIDTH  = 21;
    localparam int ADDR_WIDTH = 16;
    localparam int OPC_WIDTH  = 5;

    localparam logic [ADDR_WIDTH-1:0] RESET_VECTOR = 16'h0000;

    // Opcode map; only JMP_OPC is resolved inside the fetch sequencer.
    localparam logic [OPC_WIDTH-1:0] OPC_NOP   = 5'b00000;
    localparam logic [OPC_WIDTH-1:0] OPC_LOAD  = 5'b00001;
    localparam logic [OPC_WIDTH-1:0] OPC_STORE = 5'b00010;
    localparam logic [OPC_WIDTH-1:0] OPC_ADD   = 5'b00011;
    localparam logic [OPC_WIDTH-1:0] OPC_SUB   = 5'b00100;
    localparam logic [OPC_WIDTH-1:0] OPC_AND   = 5'b00101;
    localparam logic [OPC_WIDTH-1:0] OPC_OR    = 5'b00110;
    localparam logic [OPC_WIDTH-1:0] OPC_BEQ   = 5'b00111;
    localparam logic [OPC_WIDTH-1:0] OPC_BNE   = 5'b01000;
    localparam logic [OPC_WIDTH-1:0] JMP_OPC   = 5'b01001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_e;

    // Opcode lives in the top bits of the instruction word.
    function automatic logic [OPC_WIDTH-1:0] opcodeOf(input logic [ROM_WIDTH-1:0] word);
        return word[ROM_WIDTH-1 -: OPC_WIDTH];
    endfunction

    // Jump operand is the full address-width low field.
    function automatic logic [ADDR_WIDTH-1:0] operandOf(input logic [ROM_WIDTH-1:0] word);
        return word[ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/rom_fetch_sequencer_if.sv
// ROM bus plus execute-side handshake between the fetch sequencer and its neighbours.
interface rom_fetch_sequencer_if;
    import rom_fetch_sequencer_pkg::*;

    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [ROM_WIDTH-1:0]  rom_data;
    logic [ROM_WIDTH-1:0]  instr;
    logic                  instr_valid;
    logic                  instr_ready;
    logic                  branch_req;
    logic [ADDR_WIDTH-1:0] branch_target;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  halted;

    // The sequencer side.
    modport master (
        output rom_addr, instr, instr_valid, pc, halted,
        input  rom_data, instr_ready, branch_req, branch_target
    );

    // The ROM / execute side.
    modport slave (
        input  rom_addr, instr, instr_valid, pc, halted,
        output rom_data, instr_ready, branch_req, branch_target
    );

endinterface

// File: rtl/rom_fetch_sequencer.sv
// Program counter and instruction fetch controller: resolves absolute jumps locally,
// issues every other word to execute over valid/ready and halts on a jump-to-self.
module rom_fetch_sequencer
    import rom_fetch_sequencer_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    rom_fetch_sequencer_if.master        bus
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ROM_WIDTH-1:0]  instr_q, instr_d;
    logic [OPC_WIDTH-1:0]  opcode;
    logic [ADDR_WIDTH-1:0] operand;

    assign opcode  = opcodeOf(bus.rom_data);
    assign operand = operandOf(bus.rom_data);

    // Next-state, next-pc and instruction capture decisions.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (opcode == JMP_OPC) begin
                    if (operand == pc_q) begin
                        state_d = ST_HALT;
                    end else begin
                        pc_d = operand;
                    end
                end else begin
                    instr_d = bus.rom_data;
                    pc_d    = pc_q + ADDR_WIDTH'(1);
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.instr_ready) begin
                    if (bus.branch_req) begin
                        pc_d = bus.branch_target;
                    end
                    state_d = en ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pc and instruction registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_VECTOR;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign bus.rom_addr    = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = (state_q == ST_HOLD);
    assign bus.halted      = (state_q == ST_HALT);

endmodule
